axi4_default_slave: RTL and testbench

- Terminates every AXI4 transaction that the address decoder routes to no slave: unmapped addresses and accesses the decoder flags as `access_error` (permission or security violation).
- Instantiated in the interconnect alongside the slave ports; it never touches memory.
- Write bursts: accepts and discards all W beats, then returns one DECERR B response.
- Read bursts: returns ARLEN+1 DECERR beats with zero data and RLAST on the final beat, so masters never hang.

---
 rtl/axi4_default_slave_pkg.sv | 19 +
 rtl/axi4_default_slave_rd.sv | 69 ++++++
 rtl/axi4_default_slave.sv | 141 ++++++++++++++
 tb/tb_axi4_default_slave.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_default_slave_pkg.sv
// rtl/axi4_default_slave_pkg.sv - shared response codes and FSM state types for the default slave
package axi4_default_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi4_default_slave_rd.sv
// rtl/axi4_default_slave_rd.sv - read FSM returning arlen+1 zero-data DECERR beats
module axi4_default_slave_rd
    import axi4_default_slave_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    r_state_t            state;
    r_state_t            state_next;
    logic [7:0]          beat_cnt;
    logic [ID_WIDTH-1:0] id_q;

    // State register; reset drops rvalid immediately
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the burst ID and remaining-beat count on AR, count down per accepted beat
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            id_q     <= '0;
            beat_cnt <= '0;
        end else if (state == R_IDLE && arvalid) begin
            id_q     <= arid;
            beat_cnt <= arlen;
        end else if (state == R_DATA && rready && beat_cnt != 8'd0) begin
            beat_cnt <= beat_cnt - 8'd1;
        end
    end

    // Next state: leave R_DATA only when the last beat is accepted
    always_comb begin
        state_next = state;
        case (state)
            R_IDLE: if (arvalid) state_next = R_DATA;
            R_DATA: if (rready && beat_cnt == 8'd0) state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        arready = (state == R_IDLE);
        rvalid  = (state == R_DATA);
        rlast   = (state == R_DATA) && (beat_cnt == 8'd0);
        rresp   = (state == R_DATA) ? RESP_DECERR : RESP_OKAY;
        rid     = id_q;
        rdata   = '0;
    end

endmodule

// File: rtl/axi4_default_slave.sv
// rtl/axi4_default_slave.sv - AXI4 default slave terminating unmapped accesses with DECERR (option: AXI4_DEFAULT_SLAVE_ERR_LOG_EN)
module axi4_default_slave
    import axi4_default_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
    ,
    output logic [15:0]             err_count,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    err_is_write
`endif
);

    w_state_t            w_state;
    w_state_t            w_state_next;
    logic [ID_WIDTH-1:0] bid_q;

    // Write data content and burst length never matter; the burst ends on wlast
    logic unused_inputs;
    assign unused_inputs = ^{awlen, wdata, wstrb};

    // Write state register; reset drops wready/bvalid immediately
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    // Capture the write ID at the AW handshake for the eventual B response
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bid_q <= '0;
        end else if (w_state == W_IDLE && awvalid) begin
            bid_q <= awid;
        end
    end

    // Next write state: AW, then drain W until wlast, then one B
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (awvalid) w_state_next = W_DATA;
            W_DATA:  if (wvalid && wlast) w_state_next = W_RESP;
            W_RESP:  if (bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write channel outputs decoded from registered state only
    always_comb begin
        awready = (w_state == W_IDLE);
        wready  = (w_state == W_DATA);
        bvalid  = (w_state == W_RESP);
        bresp   = (w_state == W_RESP) ? RESP_DECERR : RESP_OKAY;
        bid     = bid_q;
    end

    axi4_default_slave_rd #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd (
        .aclk    (aclk),
        .areset  (areset),
        .arid    (arid),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
    logic                  aw_hs;
    logic                  ar_hs;
    logic [16:0]           err_sum;
    logic [15:0]           err_count_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic                  err_is_write_q;

    assign aw_hs   = awvalid && awready;
    assign ar_hs   = arvalid && arready;
    assign err_sum = {1'b0, err_count_q} + 17'(aw_hs) + 17'(ar_hs);

    // Log every accepted address handshake; on a tie the write address is kept
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_count_q    <= '0;
            err_addr_q     <= '0;
            err_is_write_q <= 1'b0;
        end else if (aw_hs || ar_hs) begin
            err_count_q    <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            err_addr_q     <= aw_hs ? awaddr : araddr;
            err_is_write_q <= aw_hs;
        end
    end

    assign err_count    = err_count_q;
    assign err_addr     = err_addr_q;
    assign err_is_write = err_is_write_q;
`else
    logic unused_addr;
    assign unused_addr = ^{awaddr, araddr};
`endif

endmodule

// File: tb/tb_axi4_default_slave.sv
// tb/tb_axi4_default_slave.sv - self-checking bench for axi4_default_slave
module tb_axi4_default_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
    logic [15:0]   err_count;
    logic [AW-1:0] err_addr;
    logic          err_is_write;
`endif

    axi4_default_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
        , .err_count(err_count), .err_addr(err_addr), .err_is_write(err_is_write)
`endif
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a write is open from AW until B, a read owes a number of beats
    bit            m_wr_open = 1'b0;
    bit            m_wr_data_done = 1'b0;
    logic [IW-1:0] m_bid = '0;
    int            m_rd_left = 0;
    logic [IW-1:0] m_rid = '0;
    bit            m_aw_hs;
    bit            m_ar_hs;
    int            m_sum;
    logic [15:0]   m_err_count = '0;
    logic [AW-1:0] m_err_addr = '0;
    bit            m_err_is_write = 1'b0;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_wr_open = 0; m_wr_data_done = 0; m_bid = '0;
            m_rd_left = 0; m_rid = '0;
            m_err_count = '0; m_err_addr = '0; m_err_is_write = 0;
        end else begin
            m_aw_hs = !m_wr_open && awvalid;
            m_ar_hs = (m_rd_left == 0) && arvalid;
            if (m_wr_open && m_wr_data_done) begin
                if (bready) begin m_wr_open = 0; m_wr_data_done = 0; end
            end else if (m_wr_open) begin
                if (wvalid && wlast) m_wr_data_done = 1;
            end else if (m_aw_hs) begin
                m_wr_open = 1; m_bid = awid;
            end
            if (m_rd_left == 0) begin
                if (m_ar_hs) begin m_rd_left = int'(arlen) + 1; m_rid = arid; end
            end else if (rready) begin
                m_rd_left--;
            end
            if (m_aw_hs || m_ar_hs) begin
                m_sum = int'(m_err_count) + int'(m_aw_hs) + int'(m_ar_hs);
                m_err_count = (m_sum > 65535) ? 16'hFFFF : 16'(m_sum);
                m_err_addr = m_aw_hs ? awaddr : araddr;
                m_err_is_write = m_aw_hs;
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge aclk) begin
        if (check_en) begin
            chk("awready", awready, !m_wr_open);
            chk("wready", wready, m_wr_open && !m_wr_data_done);
            chk("bvalid", bvalid, m_wr_open && m_wr_data_done);
            if (m_wr_open && m_wr_data_done) begin
                chk("bid", bid, m_bid);
                chk("bresp", bresp, 2'b11);
            end
            chk("arready", arready, m_rd_left == 0);
            chk("rvalid", rvalid, m_rd_left > 0);
            chk("rlast", rlast, m_rd_left == 1);
            chk("rdata", rdata, 0);
            if (m_rd_left > 0) begin
                chk("rid", rid, m_rid);
                chk("rresp", rresp, 2'b11);
            end
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
            chk("err_count", err_count, m_err_count);
            chk("err_addr", err_addr, m_err_addr);
            chk("err_is_write", err_is_write, m_err_is_write);
`endif
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr);
        awvalid = 1; awid = id; awaddr = addr; awlen = 0; bready = 1;
        step(); awvalid = 0;
        wvalid = 1; wlast = 1;
        step(); wvalid = 0; wlast = 0;
        step();
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr);
        arvalid = 1; arid = id; araddr = addr; arlen = 0; rready = 1;
        step(); arvalid = 0;
        step();
    endtask

    task automatic read_count(input logic [7:0] len, output int beats, output int last_at);
        arvalid = 1; arid = 4'h9; arlen = len; rready = 1;
        step(); arvalid = 0;
        beats = 0; last_at = 0;
        for (int i = 0; i < 300; i++) begin
            if (!rvalid) break;
            beats++;
            if (rlast) last_at = beats;
            step();
        end
    endtask

    task automatic idle_inputs();
        awvalid = 0; wvalid = 0; wlast = 0; arvalid = 0; bready = 0; rready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;
        int beats;
        int last_at;
        repeat (3) @(posedge aclk);
        #1;
        areset = 0;
        check_en = 1;

        // Reset values
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);

        // Write: early W beat stalls, four beats, one B cycle
        bready = 1; wvalid = 1; wlast = 0;
        chk("w_early_wready", wready, 0);
        awvalid = 1; awid = 4'h5; awlen = 3;
        step(); awvalid = 0;
        for (int i = 0; i < 4; i++) begin
            wlast = (i == 3);
            chk("w_beat_wready", wready, 1);
            step();
        end
        wvalid = 0; wlast = 0;
        chk("w_done_wready", wready, 0);
        chk("w_bvalid", bvalid, 1);
        chk("w_bid", bid, 4'h5);
        chk("w_bresp", bresp, 2'b11);
        step();
        chk("w_bvalid_once", bvalid, 0);
        chk("w_awready_back", awready, 1);

        // Read: eight beats, rlast only on the last
        arvalid = 1; arid = 4'hA; arlen = 7; rready = 1;
        step(); arvalid = 0;
        for (int i = 0; i < 8; i++) begin
            chk("r_rvalid", rvalid, 1);
            chk("r_rid", rid, 4'hA);
            chk("r_rresp", rresp, 2'b11);
            chk("r_rlast", rlast, i == 7);
            step();
        end
        chk("r_done_rvalid", rvalid, 0);
        chk("r_arready_back", arready, 1);

        // Read backpressure
        arvalid = 1; arid = 4'h6; arlen = 2; rready = 0;
        step(); arvalid = 0;
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            rready = (i % 3 == 0);
            if (rvalid && rready) hs++;
            step();
        end
        chk("bp_handshakes", hs, 3);
        chk("bp_rvalid_end", rvalid, 0);

        // Write response backpressure
        bready = 0; awvalid = 1; awid = 4'h2;
        step(); awvalid = 0; wvalid = 1; wlast = 1;
        step(); wvalid = 0; wlast = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid_held", bvalid, 1);
            chk("bp_awready_low", awready, 0);
            step();
        end
        bready = 1;
        step();
        chk("bp_bvalid_drop", bvalid, 0);

        // Burst-length boundaries
        read_count(8'd0, beats, last_at);
        chk("len0_beats", beats, 1);
        chk("len0_last", last_at, 1);
        read_count(8'd255, beats, last_at);
        chk("len255_beats", beats, 256);
        chk("len255_last", last_at, 256);

        // Simultaneous AW and AR
        awvalid = 1; awid = 4'h3; arvalid = 1; arid = 4'hC; arlen = 1;
        rready = 1; bready = 1; wvalid = 1; wlast = 1;
        step(); awvalid = 0; arvalid = 0;
        chk("sim_wready", wready, 1);
        chk("sim_rvalid", rvalid, 1);
        chk("sim_rid", rid, 4'hC);
        step(); wvalid = 0; wlast = 0;
        chk("sim_bvalid", bvalid, 1);
        chk("sim_bid", bid, 4'h3);
        chk("sim_rlast", rlast, 1);
        step();
        chk("sim_bvalid_done", bvalid, 0);
        chk("sim_rvalid_done", rvalid, 0);

        // Reset in the middle of a read burst
        arvalid = 1; arid = 4'h7; arlen = 15; rready = 1;
        step(); arvalid = 0;
        step();
        chk("mid_rvalid_before", rvalid, 1);
        #2 areset = 1;
        #1;
        chk("mid_rvalid_async", rvalid, 0);
        chk("mid_bvalid_async", bvalid, 0);
        @(posedge aclk); #1;
        areset = 0;
        step();
        chk("mid_arready_after", arready, 1);
        chk("mid_rvalid_after", rvalid, 0);
        rready = 0;

`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
        idle_inputs();
        areset = 1; step(); areset = 0; step();
        do_write(4'h1, 32'h1000_0000);
        do_write(4'h2, 32'h2000_0000);
        do_write(4'h3, 32'h3000_0000);
        do_read(4'h4, 32'hA000_0000);
        do_read(4'h5, 32'hB000_0000);
        chk("log_count", err_count, 5);
        chk("log_addr", err_addr, 32'hB000_0000);
        chk("log_is_write", err_is_write, 0);
        idle_inputs();
        dut.err_count_q = 16'hFFFE;
        m_err_count = 16'hFFFE;
        awvalid = 1; awid = 4'h1; awaddr = 32'hC000_0004;
        arvalid = 1; arid = 4'h2; araddr = 32'hD000_0008; arlen = 0;
        step(); awvalid = 0; arvalid = 0;
        chk("sat_count", err_count, 16'hFFFF);
        chk("sat_addr", err_addr, 32'hC000_0004);
        chk("sat_is_write", err_is_write, 1);
        wvalid = 1; wlast = 1; rready = 1; bready = 1;
        step(); wvalid = 0; wlast = 0;
        step();
`endif

        // Randomized traffic with occasional asynchronous reset
        for (int c = 0; c < 4000; c++) begin
            awvalid = 1'($urandom_range(0, 1));
            awid    = 4'($urandom);
            awaddr  = $urandom;
            awlen   = 8'($urandom);
            wvalid  = 1'($urandom_range(0, 1));
            wlast   = ($urandom_range(0, 3) == 0);
            wdata   = $urandom;
            wstrb   = 4'($urandom);
            bready  = ($urandom_range(0, 3) != 0);
            arvalid = 1'($urandom_range(0, 1));
            arid    = 4'($urandom);
            araddr  = $urandom;
            arlen   = ($urandom_range(0, 63) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
            rready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 areset = 1;
                #4 areset = 0;
            end
            step();
        end

        idle_inputs();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
